seq_divider: RTL and testbench
==============================

# seq_divider

Iterative radix-2 restoring divider for the RV32M DIV/DIVU/REM/REMU group in the execute-stage mul_div unit. Each iteration does one trial subtraction through an `add` instance of width XLEN+1 with `op=1`; the instance's result and sign decide the quotient bit. Operands arrive from the execute-stage operand mux, and the registered quotient or remainder returns to the execute result mux through a start/valid handshake.

## Interface
- XLEN, 32, operand and result width.
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- start_i  in  1  request strobe; accepted only in IDLE or DONE.
- op_i  in  2  operation: 2'b00 DIV, 2'b01 DIVU, 2'b10 REM, 2'b11 REMU; sampled with start_i.
- dividend_i  in  XLEN  rs1 value; sampled with start_i.
- divisor_i  in  XLEN  rs2 value; sampled with start_i.
- flush_i  in  1  abort; has priority over start_i.
- busy_o  out  1  high in CALC and FIXUP.
- valid_o  out  1  high for exactly one cycle, in DONE.
- result_o  out  XLEN  quotient (DIV/DIVU) or remainder (REM/REMU); held stable until the next accepted start.

## Operation
- States: IDLE, CALC, FIXUP, DONE.
- Start accepted in IDLE or DONE:
  - latch op, and sign flags (signed ops only): dividend sign, and divisor-sign XOR dividend-sign;
  - load |dividend| into the quotient shift register, |divisor| into the divisor register;
  - clear the partial remainder and the 5-bit iteration counter.
- Absolute value uses two's-complement negation. |0x80000000| = 0x80000000, treated as unsigned.
- Special cases at accept, which go directly to DONE with the final result written:
  - Divisor zero: quotient = all ones; remainder = dividend_i unmodified.
  - DIV/REM with dividend 0x80000000 and divisor 0xFFFFFFFF: quotient = 0x80000000, remainder = 0.
- CALC iteration, one per cycle, XLEN cycles:
  - shift {rem, quo} left 1;
  - trial = shifted rem − divisor, computed at XLEN+1 bits with `op=1`;
  - if the trial is non-negative (MSB 0): rem ← trial, quotient LSB ← 1;
  - otherwise rem is kept and quotient LSB ← 0.
  - On counter == XLEN−1, go to FIXUP.
- FIXUP:
  - negate the quotient if the quotient-sign flag is set;
  - negate the remainder if the dividend-sign flag is set (signed ops only);
  - write the selected value to result_o; go to DONE.
- DONE: valid_o = 1.
  - Next edge: a new start is accepted if start_i is high, otherwise go to IDLE.
- Any start_i outside IDLE/DONE is ignored. The issuing stage holds its request until valid_o.
- flush_i = 1 in any state: next state IDLE; valid_o is not asserted; result_o keeps its old value. A start_i in the same cycle is dropped.

## Timing
- Reset: state IDLE, busy_o 0, valid_o 0, result_o 0, all internal registers 0.
- Normal latency: start sampled at edge E0; CALC on edges E1–E32; FIXUP updates result at E33; valid_o high in the cycle after E33. That is XLEN+2 cycles from accept to valid.
- Special-case latency: valid_o high in the cycle after E0 (1 cycle); busy_o never rises.
- Back-to-back: a start_i accepted in the DONE cycle gives valid_o and a new accept in the same cycle. busy_o rises the next cycle.
- Reset mid-operation: immediate return to reset values, independent of clock.

## Test plan
- DIVU 100 / 7 → result_o = 14, valid_o exactly 34 cycles after accept; REMU 100 / 7 → 2; busy_o high 33 cycles.
- DIV 0xFFFFFFF9 (−7) / 2 → 0xFFFFFFFD (−3); REM −7 / 2 → 0xFFFFFFFF (−1); REM 7 / −2 → 1.
- DIV 5 / 0 → 0xFFFFFFFF, and REMU 5 / 0 → 5, each with valid_o one cycle after accept and busy_o staying 0.
- DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM of the same operands → 0; DIVU 0x80000000 / 0xFFFFFFFF → 0; REMU 0xFFFFFFFF / 1 → 0.
- DIVU 1000 / 3 with flush_i at the 10th CALC cycle → no valid_o, state IDLE; the next DIVU 9 / 3 → 3 with full latency.
- start_i pulsed mid-CALC → ignored, first result unchanged. A start issued in the DONE cycle → second result 34 cycles later. rst_ni dropped mid-CALC → all outputs 0 immediately.

Source files
------------

// File: rtl/seq_divider.sv
// seq_divider: iterative radix-2 restoring divider for DIV/DIVU/REM/REMU.
// One trial subtraction per cycle through an XLEN+1 bit add/sub instance.
// Ports:
//   clk_i, rst_ni        clock, async active-low reset
//   start_i, op_i        request strobe and operation (00 DIV, 01 DIVU, 10 REM, 11 REMU)
//   dividend_i/divisor_i rs1 / rs2 operands, sampled with start_i
//   flush_i              abort, overrides start_i
//   busy_o, valid_o      busy in CALC/FIXUP, one-cycle valid in DONE
//   result_o             quotient or remainder, held until next accepted start

// Adder/subtractor: op_i=1 gives a_i - b_i, op_i=0 gives a_i + b_i.
module add #(
  parameter int unsigned W = 33
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         op_i,
  output logic [W-1:0] res_o
);
  assign res_o = op_i ? (a_i - b_i) : (a_i + b_i);
endmodule

module seq_divider #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            valid_o,
  output logic [XLEN-1:0] result_o
);
  localparam int unsigned CW = $clog2(XLEN);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIXUP, S_DONE} state_e;

  state_e          state_q, state_d;
  logic [1:0]      op_q, op_d;
  logic            qneg_q, qneg_d;
  logic            rneg_q, rneg_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] div_q, div_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            busy_q, busy_d;
  logic            valid_q, valid_d;

  // Operand conditioning at accept time (signed ops use magnitudes).
  logic            is_signed;
  logic            dvd_neg, dvs_neg;
  logic [XLEN-1:0] dvd_abs, dvs_abs;
  logic            div_zero, ovf;

  assign is_signed = ~op_i[0];
  assign dvd_neg   = is_signed & dividend_i[XLEN-1];
  assign dvs_neg   = is_signed & divisor_i[XLEN-1];
  assign dvd_abs   = dvd_neg ? XLEN'(~dividend_i + 1'b1) : dividend_i;
  assign dvs_abs   = dvs_neg ? XLEN'(~divisor_i + 1'b1) : divisor_i;
  assign div_zero  = (divisor_i == '0);
  assign ovf       = is_signed && (dividend_i == {1'b1, {(XLEN-1){1'b0}}}) && (divisor_i == '1);

  // Trial subtraction of the shifted partial remainder; MSB set means it went negative.
  logic [XLEN:0] trial;
  add #(.W(XLEN + 1)) u_sub (
    .a_i  ({rem_q, quo_q[XLEN-1]}),
    .b_i  ({1'b0, div_q}),
    .op_i (1'b1),
    .res_o(trial)
  );

  // Sign fix-up of final quotient / remainder.
  logic [XLEN-1:0] q_fin, r_fin;
  assign q_fin = qneg_q ? XLEN'(~quo_q + 1'b1) : quo_q;
  assign r_fin = rneg_q ? XLEN'(~rem_q + 1'b1) : rem_q;

  // Next-state and datapath update.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    div_d    = div_q;
    cnt_d    = cnt_q;
    result_d = result_q;

    if (flush_i) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE: begin
          state_d = S_IDLE;
          if (start_i) begin
            op_d   = op_i;
            qneg_d = dvd_neg ^ dvs_neg;
            rneg_d = dvd_neg;
            quo_d  = dvd_abs;
            div_d  = dvs_abs;
            rem_d  = '0;
            cnt_d  = '0;
            if (div_zero) begin
              result_d = op_i[1] ? dividend_i : '1;
              state_d  = S_DONE;
            end else if (ovf) begin
              result_d = op_i[1] ? '0 : dividend_i;
              state_d  = S_DONE;
            end else begin
              state_d = S_CALC;
            end
          end
        end
        S_CALC: begin
          quo_d = {quo_q[XLEN-2:0], ~trial[XLEN]};
          rem_d = trial[XLEN] ? {rem_q[XLEN-2:0], quo_q[XLEN-1]} : trial[XLEN-1:0];
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(XLEN - 1)) state_d = S_FIXUP;
        end
        S_FIXUP: begin
          result_d = op_q[1] ? r_fin : q_fin;
          state_d  = S_DONE;
        end
        default: state_d = S_IDLE;
      endcase
    end

    busy_d  = (state_d == S_CALC) || (state_d == S_FIXUP);
    valid_d = (state_d == S_DONE);
  end

  // State and datapath registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      quo_q    <= '0;
      rem_q    <= '0;
      div_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      div_q    <= div_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      valid_q  <= valid_d;
    end
  end

  assign busy_o   = busy_q;
  assign valid_o  = valid_q;
  assign result_o = result_q;
endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: stimulus pushes expected results,
// a negedge monitor pops and compares whenever valid_o is seen.
module tb_seq_divider;
  localparam logic [1:0] DIV = 2'b00, DIVU = 2'b01, REM = 2'b10, REMU = 2'b11;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        start_i = 1'b0;
  logic [1:0]  op_i = '0;
  logic [31:0] dividend_i = '0;
  logic [31:0] divisor_i = '0;
  logic        flush_i = 1'b0;
  logic        busy_o, valid_o;
  logic [31:0] result_o;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  seq_divider dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .start_i   (start_i),
    .op_i      (op_i),
    .dividend_i(dividend_i),
    .divisor_i (divisor_i),
    .flush_i   (flush_i),
    .busy_o    (busy_o),
    .valid_o   (valid_o),
    .result_o  (result_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every valid_o pops one expected result.
  always @(negedge clk_i) begin
    if (rst_ni && valid_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got result 0x%08h, expected no valid", result_o);
      end else begin
        check("result", result_o, exp_q.pop_front());
      end
    end
  end

  // Called at a negedge; start_i is sampled at the following posedge.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input bit push);
    op_i       = op;
    dividend_i = a;
    divisor_i  = b;
    start_i    = 1'b1;
    if (push) exp_q.push_back(exp);
    @(posedge clk_i);
    #1 start_i = 1'b0;
  endtask

  // Counts negedges until valid_o (bounded) and busy_o cycles on the way.
  task automatic wait_valid(input string name, input int exp_lat, input int exp_busy);
    int  n = 0;
    int  nb = 0;
    bit  seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk_i);
      n++;
      if (busy_o) nb++;
      if (valid_o) seen = 1'b1;
    end
    check({name, "_latency"}, 32'(n), 32'(exp_lat));
    check({name, "_busy_cycles"}, 32'(nb), 32'(exp_busy));
  endtask

  initial begin
    bit bad;
    #12;
    check("reset_busy", 32'(busy_o), 32'd0);
    check("reset_valid", 32'(valid_o), 32'd0);
    check("reset_result", result_o, 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);

    issue(DIVU, 32'd100, 32'd7, 32'd14, 1'b1);               wait_valid("divu_100_7", 34, 33);
    issue(REMU, 32'd100, 32'd7, 32'd2, 1'b1);                wait_valid("remu_100_7", 34, 33);
    issue(DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 1'b1);     wait_valid("div_m7_2", 34, 33);
    issue(REM, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 1'b1);     wait_valid("rem_m7_2", 34, 33);
    issue(REM, 32'd7, 32'hFFFFFFFE, 32'd1, 1'b1);            wait_valid("rem_7_m2", 34, 33);
    issue(DIV, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 1'b1);     wait_valid("div_m100_7", 34, 33);
    issue(REM, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFFE, 1'b1);     wait_valid("rem_m100_7", 34, 33);
    issue(DIV, 32'd5, 32'd0, 32'hFFFFFFFF, 1'b1);            wait_valid("div_5_0", 1, 0);
    issue(REMU, 32'd5, 32'd0, 32'd5, 1'b1);                  wait_valid("remu_5_0", 1, 0);
    issue(REM, 32'h80000000, 32'd0, 32'h80000000, 1'b1);     wait_valid("rem_min_0", 1, 0);
    issue(DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1); wait_valid("div_ovf", 1, 0);
    issue(REM, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1'b1);     wait_valid("rem_ovf", 1, 0);
    issue(DIVU, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1'b1);    wait_valid("divu_big", 34, 33);
    issue(REMU, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b1);           wait_valid("remu_max_1", 34, 33);

    // Back-to-back: second request issued in the DONE cycle of the first.
    issue(DIVU, 32'd1000, 32'd3, 32'd333, 1'b1);             wait_valid("b2b_first", 34, 33);
    issue(REMU, 32'd1000, 32'd3, 32'd1, 1'b1);               wait_valid("b2b_second", 34, 33);
    @(negedge clk_i);

    // Flush at the 10th CALC cycle: no valid, result held.
    issue(DIVU, 32'd1000, 32'd3, 32'd0, 1'b0);
    repeat (9) @(negedge clk_i);
    flush_i = 1'b1;
    @(posedge clk_i);
    #1 flush_i = 1'b0;
    bad = 1'b0;
    repeat (40) begin
      @(negedge clk_i);
      if (valid_o || busy_o) bad = 1'b1;
    end
    check("flush_quiet", 32'(bad), 32'd0);
    check("flush_hold", result_o, 32'd1);
    issue(DIVU, 32'd9, 32'd3, 32'd3, 1'b1);                  wait_valid("after_flush", 34, 33);
    @(negedge clk_i);

    // Start pulsed mid-CALC must be ignored.
    issue(DIVU, 32'd100, 32'd7, 32'd14, 1'b1);
    repeat (5) @(negedge clk_i);
    op_i = DIVU; dividend_i = 32'd55; divisor_i = 32'd5; start_i = 1'b1;
    @(posedge clk_i);
    #1 start_i = 1'b0;
    wait_valid("midcalc_start", 29, 28);
    @(negedge clk_i);

    // Asynchronous reset mid-CALC.
    issue(DIVU, 32'd1000, 32'd3, 32'd0, 1'b0);
    repeat (10) @(negedge clk_i);
    #2 rst_ni = 1'b0;
    #1;
    check("midreset_busy", 32'(busy_o), 32'd0);
    check("midreset_valid", 32'(valid_o), 32'd0);
    check("midreset_result", result_o, 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    issue(DIV, 32'd20, 32'hFFFFFFFB, 32'hFFFFFFFC, 1'b1);    wait_valid("div_20_m5", 34, 33);
    repeat (2) @(negedge clk_i);

    check("pending_results", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
